// File: rtl/tflip.sv
// Bank of WIDTH independent T flip-flops whose previous state arrives on qpr.
// Each rising edge registers t XOR qpr; qn is the inverted output of the same register.
module tflip #(
   parameter int              WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   input  logic [WIDTH-1:0] qpr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;

   // Bit-sliced toggle equation: no coupling between cells.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         assign state_d[gi] = t[gi] ^ qpr[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RESET_VAL;
      end else begin
         state_q <= state_d;
      end
   end

   // A single register feeds both outputs so qn can never disagree with q.
   assign q  = state_q;
   assign qn = ~state_q;

endmodule

// File: tb/tb_tflip.sv
// Bench for tflip: directed edge cases plus randomized traffic compared against
// a per-bit modulo-2 model; two instances with different reset values.
module tb_tflip;

   localparam int         W    = 4;
   localparam logic [3:0] RV_A = 4'b0000;
   localparam logic [3:0] RV_B = 4'b1001;
   localparam logic [3:0] ONES = 4'b1111;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] t;
   logic [W-1:0] qpr;
   logic [W-1:0] q_a, qn_a, q_b, qn_b;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_a, exp_b;
   bit           model_valid = 1'b0;

   always #5 clk = ~clk;

   tflip #(.WIDTH(W), .RESET_VAL(RV_A)) dut_a (
      .clk(clk), .rst(rst), .t(t), .qpr(qpr), .q(q_a), .qn(qn_a)
   );

   tflip #(.WIDTH(W), .RESET_VAL(RV_B)) dut_b (
      .clk(clk), .rst(rst), .t(t), .qpr(qpr), .q(q_b), .qn(qn_b)
   );

   // Model: each cell's next state is the sum of its toggle request and prior state, mod 2.
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         exp_a <= RV_A;
         exp_b <= RV_B;
      end else begin
         for (int i = 0; i < W; i++) begin
            exp_a[i] <= 1'((int'(qpr[i]) + int'(t[i])) % 2);
            exp_b[i] <= 1'((int'(qpr[i]) + int'(t[i])) % 2);
         end
      end
      model_valid <= 1'b1;
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   // Continuous comparison, away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         chk("model_q_a",  q_a,  exp_a);
         chk("model_qn_a", qn_a, ~exp_a);
         chk("model_q_b",  q_b,  exp_b);
         chk("model_qn_b", qn_b, ~exp_b);
         chk("qn_is_not_q_a", qn_a, ~q_a);
      end
   end

   task automatic step(input logic r, input logic [W-1:0] tv, input logic [W-1:0] pv);
      rst = r;
      t   = tv;
      qpr = pv;
      @(posedge clk);
      #1;
      $display("edge rst=%b t=%b qpr=%b -> q_a=%b qn_a=%b q_b=%b", r, tv, pv, q_a, qn_a, q_b);
   endtask

   initial begin
      rst = 1'b1;
      t   = ONES;
      qpr = ONES;
      @(negedge clk);

      // Reset ignores t and qpr.
      step(1'b1, ONES, ONES);
      chk("reset_q_a",  q_a,  4'b0000);
      chk("reset_qn_a", qn_a, 4'b1111);
      chk("reset_q_b",  q_b,  4'b1001);
      chk("reset_qn_b", qn_b, 4'b0110);

      step(1'b0, 4'b0000, ONES);
      chk("hold_one", q_a, 4'b1111);
      step(1'b0, ONES, ONES);
      chk("toggle_to_zero", q_a, 4'b0000);
      chk("toggle_to_zero_qn", qn_a, 4'b1111);
      step(1'b0, ONES, 4'b0000);
      chk("toggle_to_one", q_a, 4'b1111);
      step(1'b0, 4'b0000, 4'b0000);
      chk("hold_zero", q_a, 4'b0000);

      // qpr wiggles between edges must not reach the outputs.
      t   = 4'b0000;
      qpr = ONES;
      #2 qpr = 4'b0000;
      #1 chk("no_comb_path", q_a, 4'b0000);
      qpr = ONES;
      @(posedge clk);
      #1;
      $display("edge rst=0 t=0000 qpr=1111 (after wiggle) -> q_a=%b", q_a);
      chk("edge_sampled_qpr", q_a, 4'b1111);

      step(1'b0, 4'b1010, 4'b0110);
      chk("mixed_q_a",  q_a,  4'b1100);
      chk("mixed_qn_a", qn_a, 4'b0011);
      chk("mixed_q_b",  q_b,  4'b1100);

      // Reset wins over a simultaneous toggle.
      step(1'b1, ONES, 4'b0000);
      chk("reset_overrides_a", q_a, 4'b0000);
      chk("reset_overrides_b", q_b, 4'b1001);

      for (int n = 0; n < 300; n++) begin
         step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
              W'($urandom), W'($urandom));
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
